// File: rtl/hb_dec_seq_if.sv
// Signal bundle between the halfband decimator sequencer and its environment:
// sample stream, coefficient load port, status and the pre-add RAM ports.
interface hb_dec_seq_if #(
  parameter int COEF_W = 18
);
  // Strobes carry no backpressure: a strobe is a one-cycle valid pulse and the
  // data beside it is meaningful only in that cycle (data_out is held afterwards).
  logic                     enable;
  logic                     strobe_in;
  logic signed [15:0]       data_in;
  logic                     strobe_out;
  logic signed [15:0]       data_out;
  logic                     coef_we;
  logic [2:0]               coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     busy;
  logic                     overrun;
  logic                     ram_write;
  logic [3:0]               ram_wr_addr;
  logic signed [15:0]       ram_wr_data;
  logic [3:0]               ram_rd_addr1;
  logic [3:0]               ram_rd_addr2;
  logic signed [15:0]       ram_sum;
  logic [1:0]               dbg_state;

  modport slave (
    input  enable, strobe_in, data_in, coef_we, coef_addr, coef_data, ram_sum,
    output strobe_out, data_out, busy, overrun, ram_write, ram_wr_addr, ram_wr_data,
           ram_rd_addr1, ram_rd_addr2, dbg_state
  );

  modport master (
    output enable, strobe_in, data_in, coef_we, coef_addr, coef_data, ram_sum,
    input  strobe_out, data_out, busy, overrun, ram_write, ram_wr_addr, ram_wr_data,
           ram_rd_addr1, ram_rd_addr2, dbg_state
  );
endinterface

// File: rtl/hb_dec_seq.sv
// Sequencer/MAC for a 31-tap halfband decimate-by-2 built around an external
// 16-entry symmetric pre-add RAM; one output every two accepted input samples.
module hb_dec_seq #(
  parameter int ACC_W  = 38,
  parameter int COEF_W = 18
) (
  input  logic         clock,
  input  logic         reset,
  hb_dec_seq_if.slave  io
);
  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam int PROD_W = 16 + COEF_W;
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(65536);
  localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_LO   = ACC_W'(-32768);

  state_t                   state, state_nx;
  logic [3:0]               cnt, cnt_nx;
  logic [3:0]               wp;
  logic                     phase;
  logic signed [15:0]       dly    [8];
  logic signed [COEF_W-1:0] shadow [8];
  logic signed [COEF_W-1:0] active [8];
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [15:0]       sat;
  logic                     accept, take_odd, start, drop;
  logic [2:0]               rd_j, mul_j;
  logic                     strobe_out_q, overrun_q;
  logic signed [15:0]       data_out_q;

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_CLEAR;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state, input qualification and RAM port drive
  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    accept          = io.strobe_in & io.enable & (state != S_CLEAR);
    take_odd        = accept & phase;
    start           = accept & ~phase & (state == S_IDLE);
    drop            = accept & ~phase & (state == S_RUN);
    rd_j            = cnt[2:0] - 3'd1;
    mul_j           = 3'(cnt - 4'd3);
    io.ram_write    = 1'b0;
    io.ram_wr_addr  = 4'd0;
    io.ram_wr_data  = 16'sd0;
    io.ram_rd_addr1 = 4'd0;
    io.ram_rd_addr2 = 4'd0;

    unique case (state)
      S_CLEAR: begin
        cnt_nx = cnt + 4'd1;
        if (cnt == 4'd15) state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (start) begin
          state_nx = S_RUN;
          cnt_nx   = 4'd1;
        end
      end
      S_RUN: begin
        cnt_nx = cnt + 4'd1;
        if (cnt == 4'd12) begin
          state_nx = S_IDLE;
          cnt_nx   = 4'd0;
        end
      end
      default: state_nx = S_CLEAR;
    endcase

    // RAM ports stay quiet while reset is held so every output reads 0
    if (!reset) begin
      if (state == S_CLEAR) begin
        io.ram_write   = 1'b1;
        io.ram_wr_addr = cnt;
      end else if (start) begin
        io.ram_write   = 1'b1;
        io.ram_wr_addr = wp;
        io.ram_wr_data = io.data_in;
      end
      // wp has already advanced past the newest sample: pair newest-j with oldest+j
      if (state == S_RUN && cnt <= 4'd8) begin
        io.ram_rd_addr1 = wp - 4'd1 - {1'b0, rd_j};
        io.ram_rd_addr2 = wp + {1'b0, rd_j};
      end
    end
  end

  // Round half up at bit 17, then clamp to 16 bits
  always_comb begin
    rnd = (acc + RND_HALF) >>> 17;
    if (rnd > SAT_HI)      sat = 16'sh7fff;
    else if (rnd < SAT_LO) sat = 16'sh8000;
    else                   sat = rnd[15:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wp           <= 4'd0;
      phase        <= 1'b0;
      overrun_q    <= 1'b0;
      strobe_out_q <= 1'b0;
      data_out_q   <= 16'sd0;
      prod         <= '0;
      acc          <= '0;
      for (int i = 0; i < 8; i++) begin
        dly[i]    <= 16'sd0;
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      strobe_out_q <= 1'b0;
      if (io.coef_we) shadow[io.coef_addr] <= io.coef_data;
      if (take_odd) begin
        dly[0] <= io.data_in;
        for (int i = 1; i < 8; i++) dly[i] <= dly[i-1];
        phase <= 1'b0;
      end
      if (drop) overrun_q <= 1'b1;
      if (start) begin
        wp    <= wp + 4'd1;
        phase <= 1'b1;
        for (int i = 0; i < 8; i++) active[i] <= shadow[i];
        // Center tap is 0.5: the odd-phase sample lands at weight 2^16 of 2^17
        acc <= {{(ACC_W-32){dly[7][15]}}, dly[7], 16'd0};
      end
      if (state == S_RUN) begin
        if (cnt >= 4'd3 && cnt <= 4'd10) prod <= io.ram_sum * active[mul_j];
        if (cnt >= 4'd4 && cnt <= 4'd11) acc <= acc + ACC_W'(prod);
        if (cnt == 4'd12) begin
          data_out_q   <= sat;
          strobe_out_q <= 1'b1;
        end
      end
    end
  end

  assign io.strobe_out = strobe_out_q;
  assign io.data_out   = data_out_q;
  assign io.overrun    = overrun_q;
  assign io.busy       = ~reset & (state != S_IDLE);
  assign io.dbg_state  = state;
endmodule
